// File: rtl/twiddle_cmul.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_cmul
//  Purpose  : Three-stage pipelined complex twiddle multiplier feeding the
//             radix-2 butterfly add/sub stage. Forms B*W in Q1.(TW-1) with
//             round-half-up and saturation, and delays A so that A and B*W
//             leave the block on the same beat.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst               clock (rising edge), asynchronous active-high reset
//    in_valid / in_ready    input handshake
//    a_re, a_im  [DW-1:0]   butterfly upper input A (passed through)
//    b_re, b_im  [DW-1:0]   butterfly lower input B
//    w_re, w_im  [TW-1:0]   twiddle factor W, signed Q1.(TW-1)
//    out_valid / out_ready  output handshake
//    a_re_o, a_im_o         A aligned with the product
//    bw_re, bw_im           rounded, saturated B*W
// ============================================================================
module twiddle_cmul #(
  parameter int DW = 32,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [TW-1:0] w_re,
  input  logic [TW-1:0] w_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a_re_o,
  output logic [DW-1:0] a_im_o,
  output logic [DW-1:0] bw_re,
  output logic [DW-1:0] bw_im
);

  // Product width and the width of the sum of two products (one guard bit so
  // the add/sub of two full-scale products can never wrap).
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;

  // Half an LSB of the final result, added before the arithmetic shift.
  localparam logic signed [SW-1:0] ROUND_BIAS =
    {{(SW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  // Representable output range, expressed at sum width for comparison.
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Global pipeline control: the whole pipe moves as one unit. It may advance
  // whenever the output slot is empty or is being drained this cycle.
  // --------------------------------------------------------------------------
  logic advance;
  logic v1, v2, v3;

  assign advance  = out_ready | ~v3;
  assign in_ready = advance;

  // --------------------------------------------------------------------------
  // S1: register the raw inputs.
  // --------------------------------------------------------------------------
  logic [DW-1:0] a1_re, a1_im;
  logic [DW-1:0] b1_re, b1_im;
  logic [TW-1:0] w1_re, w1_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      a1_re <= '0;
      a1_im <= '0;
      b1_re <= '0;
      b1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
    end else if (advance) begin
      v1    <= in_valid;
      a1_re <= a_re;
      a1_im <= a_im;
      b1_re <= b_re;
      b1_im <= b_im;
      w1_re <= w_re;
      w1_im <= w_im;
    end
  end

  // --------------------------------------------------------------------------
  // S1 -> S2: four signed partial products at full width. Operands are
  // sign-extended to the product width first, so the truncated PW-bit result
  // of the multiply is the exact signed product.
  // --------------------------------------------------------------------------
  logic signed [PW-1:0] bx_re, bx_im, wx_re, wx_im;
  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;

  assign bx_re = {{TW{b1_re[DW-1]}}, b1_re};
  assign bx_im = {{TW{b1_im[DW-1]}}, b1_im};
  assign wx_re = {{DW{w1_re[TW-1]}}, w1_re};
  assign wx_im = {{DW{w1_im[TW-1]}}, w1_im};

  assign m_rr = bx_re * wx_re;
  assign m_ii = bx_im * wx_im;
  assign m_ri = bx_re * wx_im;
  assign m_ir = bx_im * wx_re;

  logic [DW-1:0]        a2_re, a2_im;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      a2_re <= '0;
      a2_im <= '0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ri  <= '0;
      p_ir  <= '0;
    end else if (advance) begin
      v2    <= v1;
      a2_re <= a1_re;
      a2_im <= a1_im;
      p_rr  <= m_rr;
      p_ii  <= m_ii;
      p_ri  <= m_ri;
      p_ir  <= m_ir;
    end
  end

  // --------------------------------------------------------------------------
  // S2 -> S3: combine products, round half-up, saturate to DW bits.
  // --------------------------------------------------------------------------
  logic signed [SW-1:0] sum_re, sum_im;
  logic signed [SW-1:0] rnd_re, rnd_im;
  logic signed [SW-1:0] sh_re,  sh_im;
  logic [DW-1:0]        sat_re, sat_im;

  assign sum_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
  assign sum_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};

  // Adding half an LSB then shifting arithmetically rounds ties toward +inf.
  assign rnd_re = sum_re + ROUND_BIAS;
  assign rnd_im = sum_im + ROUND_BIAS;
  assign sh_re  = rnd_re >>> (TW-1);
  assign sh_im  = rnd_im >>> (TW-1);

  function automatic logic [DW-1:0] saturate(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)
      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SAT_MIN)
      return {1'b1, {(DW-1){1'b0}}};
    else
      return v[DW-1:0];
  endfunction

  assign sat_re = saturate(sh_re);
  assign sat_im = saturate(sh_im);

  logic [DW-1:0] a3_re, a3_im, r3_re, r3_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      a3_re <= '0;
      a3_im <= '0;
      r3_re <= '0;
      r3_im <= '0;
    end else if (advance) begin
      v3    <= v2;
      a3_re <= a2_re;
      a3_im <= a2_im;
      r3_re <= sat_re;
      r3_im <= sat_im;
    end
  end

  // S3 drives the outputs directly; a stalled beat is held because the whole
  // pipe is frozen while advance is low.
  assign out_valid = v3;
  assign a_re_o    = a3_re;
  assign a_im_o    = a3_im;
  assign bw_re     = r3_re;
  assign bw_im     = r3_im;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_cmul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_twiddle_cmul
//  Purpose  : Self-checking bench for twiddle_cmul. A scoreboard of expected
//             beats is filled from a 64-bit arithmetic reference model on
//             every input accept and drained on every output pop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_twiddle_cmul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic [15:0] w_re, w_im;
  logic [31:0] a_re_o, a_im_o, bw_re, bw_im;

  twiddle_cmul #(.DW(32), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_re_o(a_re_o), .a_im_o(a_im_o), .bw_re(bw_re), .bw_im(bw_im)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a_re, a_im, bw_re, bw_im;
  } beat_t;

  beat_t exp_q[$];

  function automatic logic [31:0] rnd_sat(input longint p);
    longint r;
    r = (p + 64'sd16384) >>> 15;
    if (r > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (r < -64'sd2147483648) return 32'h8000_0000;
    return r[31:0];
  endfunction

  function automatic beat_t model(input logic [31:0] ar, ai, br, bi,
                                  input logic [15:0] wr, wi);
    beat_t  e;
    longint brl, bil, wrl, wil;
    brl = longint'($signed(br));
    bil = longint'($signed(bi));
    wrl = longint'($signed(wr));
    wil = longint'($signed(wi));
    e.a_re  = ar;
    e.a_im  = ai;
    e.bw_re = rnd_sat(brl * wrl - bil * wil);
    e.bw_im = rnd_sat(brl * wil + bil * wrl);
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] last_a_re, last_a_im, last_bw_re, last_bw_im;
  int          popped = 0;
  int          ncyc = 0;
  bit          tp_mode = 0;
  int          tp_first_acc, tp_first_out, tp_last_out, tp_outs;
  bit          prev_stall = 0;
  beat_t       held;

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        exp_q.delete();
        prev_stall = 0;
      end else begin
        check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
        if (prev_stall && out_valid) begin
          check("hold_a_re",  a_re_o, held.a_re);
          check("hold_a_im",  a_im_o, held.a_im);
          check("hold_bw_re", bw_re,  held.bw_re);
          check("hold_bw_im", bw_im,  held.bw_im);
        end
        prev_stall = out_valid && !out_ready;
        held = '{a_re_o, a_im_o, bw_re, bw_im};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("stray_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("a_re_o", a_re_o, e.a_re);
            check("a_im_o", a_im_o, e.a_im);
            check("bw_re",  bw_re,  e.bw_re);
            check("bw_im",  bw_im,  e.bw_im);
            popped++;
            last_a_re = a_re_o; last_a_im = a_im_o;
            last_bw_re = bw_re; last_bw_im = bw_im;
          end
          if (tp_mode) begin
            if (tp_first_out < 0) tp_first_out = ncyc;
            tp_last_out = ncyc;
            tp_outs++;
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im));
          if (tp_mode && tp_first_acc < 0) tp_first_acc = ncyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input logic [31:0] ar, ai, br, bi, input logic [15:0] wr, wi);
    int n = 0;
    bit ok = 0;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic send_random();
    logic [31:0] br, bi;
    logic [15:0] wr, wi;
    br = $urandom; bi = $urandom; wr = $urandom; wi = $urandom;
    case ($urandom_range(0, 7))
      0: wr = 16'h8000;
      1: begin br = 32'h8000_0000; wr = 16'h8000; end
      2: begin bi = 32'h7FFF_FFFF; wi = 16'h8000; end
      default: ;
    endcase
    send($urandom, $urandom, br, bi, wr, wi);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bw_re", bw_re, 32'd0);
    check("rst_a_re_o", a_re_o, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // identity twiddle
    send(32'd5, 32'd6, 32'd1000, -32'sd1000, 16'h7FFF, 16'h0000);
    drain();
    check("id_bw_re", last_bw_re, 32'd1000);
    check("id_bw_im", last_bw_im, -32'sd1000);
    check("id_a_re",  last_a_re,  32'd5);
    check("id_a_im",  last_a_im,  32'd6);

    // half scale: ties round toward +inf
    send(32'd0, 32'd0, 32'd3, -32'sd3, 16'h4000, 16'h0000);
    drain();
    check("half_bw_re", last_bw_re, 32'd2);
    check("half_bw_im", last_bw_im, -32'sd1);

    // rotation by j
    send(32'd1, 32'd2, 32'd100, 32'd200, 16'h0000, 16'h7FFF);
    drain();
    check("rot_bw_re", last_bw_re, -32'sd200);
    check("rot_bw_im", last_bw_im, 32'd100);

    // -1.0 twiddle on extreme inputs
    send(32'd0, 32'd0, 32'h8000_0000, 32'd0, 16'h8000, 16'h0000);
    drain();
    check("sat_bw_re", last_bw_re, 32'h7FFF_FFFF);
    check("sat_bw_im", last_bw_im, 32'd0);
    send(32'd0, 32'd0, 32'h7FFF_FFFF, 32'd0, 16'h8000, 16'h0000);
    drain();
    check("neg_bw_re", last_bw_re, 32'h8000_0001);

    // backpressure: out_ready pattern 1,0,0,1 repeating
    popped = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_random();
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = ((k % 4) == 0) || ((k % 4) == 3);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("bp_count", popped, 32'd8);

    // reset with three beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_random();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_bw_re", bw_re, 32'd0);
    check("mid_rst_bw_im", bw_im, 32'd0);
    check("mid_rst_a_im_o", a_im_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    popped = 0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_popped", popped, 32'd0);

    // throughput: 16 back-to-back beats
    tp_first_acc = -1; tp_first_out = -1; tp_last_out = -1; tp_outs = 0;
    tp_mode = 1;
    for (int i = 0; i < 16; i++) send_random();
    drain();
    tp_mode = 0;
    check("tp_latency", tp_first_out - tp_first_acc, 32'd3);
    check("tp_outs", tp_outs, 32'd16);
    check("tp_contig", tp_last_out - tp_first_out + 1, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
